// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = 8;

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channels between the LSU and the responder.
interface dmem_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_LANES-1:0]  req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word array with per-byte write enables; no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [NUM_LANES-1:0]        be,
  input  logic [IDX_W-1:0]            waddr,
  input  logic [NUM_LANES*LANE_W-1:0] wdata,
  output logic [NUM_LANES*LANE_W-1:0] rdata
);

  logic [NUM_LANES*LANE_W-1:0] mem [DEPTH_WORDS];

  // Lane-masked write or registered word read, one access per enable.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (be[i]) begin
            mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
          end
        end
      end else begin
        rdata <= mem[waddr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// accesses the word array once and holds the response until it is taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  dmem_state_t state;
  logic [CNT_W-1:0] cnt;

  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [NUM_LANES-1:0]  cap_be;

  logic rsp_valid_q;
  logic rsp_err_q;
  logic load_ok_q;

  logic                  accept;
  logic                  enter_resp;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [NUM_LANES-1:0]  acc_be;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Select the transaction that enters RESP this cycle and qualify its address.
  // With no wait cycles the accept edge is also the RESP-entry edge, so the
  // live request inputs are used instead of the not-yet-loaded capture regs.
  always_comb begin
    accept = (state == IDLE) && bus.req_valid;
    if (WAIT_CYCLES == 0) begin
      acc_we     = bus.req_we;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
      acc_be     = bus.req_be;
      enter_resp = accept;
    end else begin
      acc_we     = cap_we;
      acc_addr   = cap_addr;
      acc_wdata  = cap_wdata;
      acc_be     = cap_be;
      enter_resp = (state == WAIT) && (cnt == CNT_W'(1));
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (enter_resp && !acc_err),
    .we   (acc_we),
    .be   (acc_be),
    .waddr(acc_addr[IDX_W+1:2]),
    .wdata(acc_wdata),
    .rdata(arr_rdata)
  );

  // Control FSM with capture, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_be      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      load_ok_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= bus.req_we;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
            cnt       <= CNT_LOAD;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_ok_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      // RESP entry overrides the per-state next state (covers the zero-wait
      // accept edge as well as the last WAIT cycle).
      if (enter_resp) begin
        state       <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        load_ok_q   <= !acc_we && !acc_err;
      end
    end
  end

  // Read data is shown only for a successful load; the array output register
  // is not touched again until the next transaction, so it stays stable.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = load_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one responder with WAIT_CYCLES=1 and one with
// WAIT_CYCLES=0 share the stimulus; sel picks which one is exercised.
module tb_dmem_responder;

  logic clk;
  logic rst;
  logic sel;
  int unsigned cur_wc;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;

  int tests;
  int fails;

  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  assign bus0.req_valid = req_valid && !sel;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.req_be    = req_be;
  assign bus0.rsp_ready = rsp_ready && !sel;

  assign bus1.req_valid = req_valid && sel;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_be    = req_be;
  assign bus1.rsp_ready = rsp_ready && sel;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  assign o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign o_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign o_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  assign o_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

  dmem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(1)
  ) dut_w1 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  dmem_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0)
  ) dut_w0 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction with latency, payload and handshake checks.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err, input logic early);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(o_req_ready), 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    rsp_ready = early;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        req_valid = 1'b0;
        req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata; req_be = ~be;
      end
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(cur_wc + 1));
    check({tag, "_rdata"}, o_rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_vclr"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_dclr"}, o_rsp_rdata, 32'd0);
    check({tag, "_eclr"}, 32'(o_rsp_err), 32'd0);
    check({tag, "_idle"}, 32'(o_req_ready), 32'd1);
  endtask

  task automatic back_pressure();
    int seen;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = 4'hF;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      req_addr = 32'h1000;
      if (o_rsp_valid) begin
        seen = 1;
        break;
      end
    end
    check("bp_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rdata", o_rsp_rdata, 32'hDEADBEAA);
      check("bp_err", 32'(o_rsp_err), 32'd0);
      check("bp_ready", 32'(o_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_rel_valid", 32'(o_rsp_valid), 32'd0);
    check("bp_rel_ready", 32'(o_req_ready), 32'd1);
  endtask

  task automatic reset_mid();
    xact("rm_pre", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_be = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rm_valid", 32'(o_rsp_valid), 32'd0);
    check("rm_ready", 32'(o_req_ready), 32'd1);
    check("rm_rdata", o_rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rm_novalid", 32'(o_rsp_valid), 32'd0);
    end
    // With no wait cycles the write edge is the accept edge, already passed.
    xact("rm_load", 1'b0, 32'h20, 32'h0, 4'hF,
         (cur_wc == 0) ? 32'h99999999 : 32'h11111111, 1'b0, 1'b0);
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; sel = 1'b0; cur_wc = 1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;

    #3;
    rst = 1'b1;
    #1;
    check("rst_ready0", 32'(bus0.req_ready), 32'd1);
    check("rst_valid0", 32'(bus0.rsp_valid), 32'd0);
    check("rst_rdata0", bus0.rsp_rdata, 32'd0);
    check("rst_err0", 32'(bus0.rsp_err), 32'd0);
    check("rst_ready1", 32'(bus1.req_ready), 32'd1);
    check("rst_valid1", 32'(bus1.rsp_valid), 32'd0);
    check("rst_rdata1", bus1.rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      cur_wc = (s == 1) ? 0 : 1;
      xact("st_full",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 1'b0);
      xact("ld_full",  1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEEF, 1'b0, 1'b0);
      xact("st_lane0", 1'b1, 32'h10,  32'h000000AA, 4'b0001, 32'h0,        1'b0, 1'b1);
      xact("ld_lane0", 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEAA, 1'b0, 1'b0);
      xact("st_mis",   1'b1, 32'h12,  32'h55555555, 4'hF,    32'h0,        1'b1, 1'b0);
      xact("ld_mis",   1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEAA, 1'b0, 1'b0);
      xact("ld_oor",   1'b0, 32'h1000, 32'h0,       4'hF,    32'h0,        1'b1, 1'b0);
      xact("st_top",   1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF,    32'h0,        1'b0, 1'b0);
      xact("ld_top",   1'b0, 32'hFFC, 32'h0,        4'hF,    32'hCAFEF00D, 1'b0, 1'b1);
      xact("st_be0",   1'b1, 32'h10,  32'hFFFFFFFF, 4'h0,    32'h0,        1'b0, 1'b0);
      xact("ld_be0",   1'b0, 32'h10,  32'h0,        4'hF,    32'hDEADBEAA, 1'b0, 1'b0);
      back_pressure();
      reset_mid();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
